// File: rtl/ddc_block_reader.sv
// ddc_block_reader: E-DDC / EDID fetch engine. Sequences START/WRITE/READ/STOP
// commands on a shared I2C controller, stores the received bytes in a local
// buffer, and validates per-128-byte checksums and the EDID base header.
module ddc_block_reader #(
   parameter logic [6:0] DEV_ADDR    = 7'h50,
   parameter logic [6:0] SEG_ADDR    = 7'h30,
   parameter int         MAX_BYTES   = 256,
   parameter bit         USE_SEGMENT = 1'b1,
   localparam int        AW          = $clog2(MAX_BYTES)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_start,
   input  logic [7:0]    i_segment,
   input  logic [7:0]    i_offset,
   input  logic [AW:0]   i_length,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_checksumOk,
   output logic          o_headerOk,
   output logic [AW:0]   o_bytesRead,
   output logic [1:0]    o_instructionI2C,
   output logic          o_enableI2C,
   output logic [7:0]    o_byteToSendI2C,
   input  logic [7:0]    i_byteReceivedI2C,
   input  logic          i_completeI2C,
   input  logic [AW-1:0] i_rdAddr,
   output logic [7:0]    o_rdData
);

   localparam logic [1:0] I_START = 2'd0;
   localparam logic [1:0] I_STOP  = 2'd1;
   localparam logic [1:0] I_READ  = 2'd2;
   localparam logic [1:0] I_WRITE = 2'd3;
   localparam logic [AW:0] MAX_LEN = (AW+1)'(MAX_BYTES);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_SEG_W, S_SEG_DATA, S_DEV_S, S_DEV_W, S_OFFSET,
      S_RESTART, S_DEV_R, S_READ, S_STORE, S_STOP, S_DONE, S_WAIT
   } state_t;

   state_t      r_state, r_ret;
   logic        r_busy, r_done, r_checksumOk, r_headerOk, r_enable, r_seenLow;
   logic [1:0]  r_instr;
   logic [7:0]  r_tx, r_rx, r_seg, r_off, r_sum, r_rdData;
   logic [AW:0] r_len, r_idx, r_bytesRead;
   logic [7:0]  r_mem [0:MAX_BYTES-1];

   logic        w_isCmd, w_wr;
   logic [1:0]  w_instr;
   logic [7:0]  w_tx, w_sumNext, w_hdrByte;
   state_t      w_ret;
   logic [AW:0] w_len, w_idxNext;

   // Out-of-range lengths (0 or beyond the buffer) read the whole buffer
   assign w_len     = (i_length == '0 || i_length > MAX_LEN) ? MAX_LEN : i_length;
   assign w_idxNext = r_idx + 1'b1;
   // Running sum restarts at every 128-byte block boundary of the buffer
   assign w_sumNext = ((r_idx[6:0] == 7'd0) ? 8'h00 : r_sum) + r_rx;
   // Base EDID header is 00 FF FF FF FF FF FF 00
   assign w_hdrByte = (r_idx[2:0] == 3'd0 || r_idx[2:0] == 3'd7) ? 8'h00 : 8'hFF;
   assign w_wr      = (r_state == S_STORE);

   // Command issued by each bus-phase state and where to resume after it completes
   always_comb begin
      w_isCmd = 1'b1;
      w_instr = I_START;
      w_tx    = 8'h00;
      w_ret   = S_IDLE;
      case (r_state)
         S_START:    w_ret = (USE_SEGMENT && r_seg != 8'h00) ? S_SEG_W : S_DEV_W;
         S_SEG_W:    begin w_instr = I_WRITE; w_tx = {SEG_ADDR, 1'b0}; w_ret = S_SEG_DATA; end
         S_SEG_DATA: begin w_instr = I_WRITE; w_tx = r_seg;            w_ret = S_DEV_S;    end
         S_DEV_S:    w_ret = S_DEV_W;
         S_DEV_W:    begin w_instr = I_WRITE; w_tx = {DEV_ADDR, 1'b0}; w_ret = S_OFFSET;   end
         S_OFFSET:   begin w_instr = I_WRITE; w_tx = r_off;            w_ret = S_RESTART;  end
         S_RESTART:  w_ret = S_DEV_R;
         S_DEV_R:    begin w_instr = I_WRITE; w_tx = {DEV_ADDR, 1'b1}; w_ret = S_READ;     end
         S_READ:     begin w_instr = I_READ;                           w_ret = S_STORE;    end
         S_STOP:     begin w_instr = I_STOP;                           w_ret = S_DONE;     end
         default:    w_isCmd = 1'b0;
      endcase
   end

   // Transfer sequencer, controller handshake and block/header checks
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_ret        <= S_IDLE;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_checksumOk <= 1'b0;
         r_headerOk   <= 1'b0;
         r_enable     <= 1'b0;
         r_seenLow    <= 1'b0;
         r_instr      <= 2'd0;
         r_tx         <= 8'h00;
         r_rx         <= 8'h00;
         r_seg        <= 8'h00;
         r_off        <= 8'h00;
         r_sum        <= 8'h00;
         r_len        <= '0;
         r_idx        <= '0;
         r_bytesRead  <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_isCmd) begin
            r_instr   <= w_instr;
            r_tx      <= w_tx;
            r_enable  <= 1'b1;
            r_seenLow <= 1'b0;
            r_ret     <= w_ret;
            r_state   <= S_WAIT;
         end else begin
            case (r_state)
               S_IDLE: if (i_start && !r_done) begin
                  r_seg        <= i_segment;
                  r_off        <= i_offset;
                  r_len        <= w_len;
                  r_idx        <= '0;
                  r_sum        <= 8'h00;
                  r_bytesRead  <= '0;
                  r_checksumOk <= 1'b1;
                  r_headerOk   <= (i_offset == 8'h00) && (w_len >= (AW+1)'(8));
                  r_busy       <= 1'b1;
                  r_state      <= S_START;
               end
               // A high completeI2C only counts after it was seen low for this command
               S_WAIT: begin
                  if (!r_seenLow) begin
                     if (!i_completeI2C) r_seenLow <= 1'b1;
                  end else if (i_completeI2C) begin
                     r_enable <= 1'b0;
                     r_rx     <= i_byteReceivedI2C;
                     r_state  <= r_ret;
                  end
               end
               S_STORE: begin
                  r_sum       <= w_sumNext;
                  r_idx       <= w_idxNext;
                  r_bytesRead <= w_idxNext;
                  if (r_idx[6:0] == 7'h7F && w_sumNext != 8'h00) r_checksumOk <= 1'b0;
                  if (r_idx < (AW+1)'(8) && r_rx != w_hdrByte)   r_headerOk   <= 1'b0;
                  r_state <= (w_idxNext == r_len) ? S_STOP : S_READ;
               end
               S_DONE: begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   // Buffer write port; contents survive reset
   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_idx[AW-1:0]] <= r_rx;
   end

   // Registered random-access read; a same-cycle store returns the old byte
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_rdData <= 8'h00;
      else         r_rdData <= r_mem[i_rdAddr];
   end

   assign o_busy           = r_busy;
   assign o_done           = r_done;
   assign o_checksumOk     = r_checksumOk;
   assign o_headerOk       = r_headerOk;
   assign o_bytesRead      = r_bytesRead;
   assign o_instructionI2C = r_instr;
   assign o_enableI2C      = r_enable;
   assign o_byteToSendI2C  = r_tx;
   assign o_rdData         = r_rdData;

endmodule

// File: tb/tb_ddc_block_reader.sv
// Bench for ddc_block_reader: I2C controller + E-DDC EEPROM model, a
// transfer-level expectation model and one per-cycle compare process.
module tb_ddc_block_reader;
   localparam int MAXB = 256;
   localparam int AW   = 8;

   logic          clk = 1'b0;
   logic          i_reset, i_start, i_completeI2C;
   logic [7:0]    i_segment, i_offset, i_byteReceivedI2C;
   logic [AW:0]   i_length;
   logic [AW-1:0] i_rdAddr;
   logic          o_busy, o_done, o_checksumOk, o_headerOk, o_enableI2C;
   logic [AW:0]   o_bytesRead;
   logic [1:0]    o_instructionI2C;
   logic [7:0]    o_byteToSendI2C, o_rdData;

   always #5 clk = ~clk;

   ddc_block_reader dut (
      .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_segment(i_segment),
      .i_offset(i_offset), .i_length(i_length), .o_busy(o_busy), .o_done(o_done),
      .o_checksumOk(o_checksumOk), .o_headerOk(o_headerOk), .o_bytesRead(o_bytesRead),
      .o_instructionI2C(o_instructionI2C), .o_enableI2C(o_enableI2C),
      .o_byteToSendI2C(o_byteToSendI2C), .i_byteReceivedI2C(i_byteReceivedI2C),
      .i_completeI2C(i_completeI2C), .i_rdAddr(i_rdAddr), .o_rdData(o_rdData)
   );

   int total = 0, bad = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // ---------------- EEPROM + I2C controller model ----------------
   logic [7:0] eeprom [0:1023];
   logic [9:0] log_q [$];
   logic [9:0] exp_q [$];
   int         m_busy = 0, m_hold = 0, m_cnt = 0, n_cmds = 0, hold_cfg = 1, n_reads = 0, ph = 3;
   logic [1:0] m_cmd;
   logic [7:0] m_dat, m_addr = 8'h00, m_seg = 8'h00, m_ptr = 8'h00;
   logic       prev_en = 1'b0;

   always @(negedge clk) begin
      if (i_reset) begin
         m_busy = 0; prev_en = 1'b0; ph = 3; m_seg = 8'h00; i_completeI2C = 1'b1;
      end else begin
         if (m_busy == 0) begin
            if (o_enableI2C && !prev_en) begin
               m_busy = 1; m_cmd = o_instructionI2C; m_dat = o_byteToSendI2C;
               m_hold = hold_cfg; m_cnt = 1 + (n_cmds % 3); n_cmds++;
               if (m_hold == 0) i_completeI2C = 1'b0;
            end
         end else if (!o_enableI2C) begin
            chk("enable_dropped_early", {31'd0, o_enableI2C}, 32'd1);
            m_busy = 0;
         end else if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) i_completeI2C = 1'b0;
         end else if (m_cnt > 1) begin
            m_cnt--;
         end else begin
            case (m_cmd)
               2'd0: ph = 0;
               2'd1: begin ph = 3; m_seg = 8'h00; end
               2'd2: begin
                  i_byteReceivedI2C = eeprom[{m_seg[1:0], m_ptr}];
                  m_ptr = m_ptr + 8'd1; n_reads++;
               end
               default: begin
                  if (ph == 0) begin m_addr = m_dat; ph = m_dat[0] ? 2 : 1; end
                  else if (ph == 1) begin
                     if (m_addr == 8'h60) m_seg = m_dat;
                     else if (m_addr == 8'hA0) m_ptr = m_dat;
                  end
               end
            endcase
            log_q.push_back({m_cmd, (m_cmd == 2'd3) ? m_dat : 8'h00});
            i_completeI2C = 1'b1;
            m_busy = 0;
         end
         prev_en = o_enableI2C;
      end
   end

   // ---------------- transfer expectations + compare process ----------------
   logic [7:0] exp_buf [0:255];
   logic [7:0] hdr [0:7] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
   logic       exp_ck, exp_hdr, rd_chk = 1'b0, rd_en_d = 1'b0, done_prev = 1'b0;
   int         exp_len, done_cnt = 0;
   logic [7:0] rd_addr_d;

   always @(negedge clk) begin
      if (!i_reset) begin
         if (o_done) begin
            chk("checksumOk", {31'd0, o_checksumOk}, {31'd0, exp_ck});
            chk("headerOk",   {31'd0, o_headerOk},   {31'd0, exp_hdr});
            chk("bytesRead",  {23'd0, o_bytesRead},  exp_len);
            chk("busy_at_done", {31'd0, o_busy}, 32'd0);
            chk("done_width", {31'd0, done_prev}, 32'd0);
            done_cnt++;
         end
         if (rd_en_d) chk("rdData", {24'd0, o_rdData}, {24'd0, exp_buf[rd_addr_d]});
         rd_en_d   = rd_chk;
         rd_addr_d = i_rdAddr;
         done_prev = o_done;
      end
   end

   task automatic fix_block(input int base);
      logic [7:0] s;
      s = 8'h00;
      for (int k = 0; k < 127; k++) s = s + eeprom[base+k];
      eeprom[base+127] = ~s + 8'd1;
   endtask

   task automatic run(input logic [7:0] seg, input logic [7:0] off, input int len,
                      input int hold, input bit poke, input int abort_at);
      int L, d0, mism, c;
      logic [7:0] s;
      L = (len == 0 || len > MAXB) ? MAXB : len;
      exp_q.delete();
      exp_q.push_back({2'd0, 8'h00});
      if (seg != 8'h00) begin
         exp_q.push_back({2'd3, 8'h60}); exp_q.push_back({2'd3, seg}); exp_q.push_back({2'd0, 8'h00});
      end
      exp_q.push_back({2'd3, 8'hA0}); exp_q.push_back({2'd3, off});
      exp_q.push_back({2'd0, 8'h00}); exp_q.push_back({2'd3, 8'hA1});
      for (int i = 0; i < L; i++) exp_q.push_back({2'd2, 8'h00});
      exp_q.push_back({2'd1, 8'h00});
      for (int i = 0; i < L; i++) exp_buf[i] = eeprom[{seg[1:0], 8'(off + i)}];
      exp_ck = 1'b1;
      for (int b = 0; (b + 1) * 128 <= L; b++) begin
         s = 8'h00;
         for (int k = 0; k < 128; k++) s = s + exp_buf[b*128+k];
         if (s != 8'h00) exp_ck = 1'b0;
      end
      exp_hdr = (off == 8'h00) && (L >= 8);
      if (L >= 8) for (int k = 0; k < 8; k++) if (exp_buf[k] != hdr[k]) exp_hdr = 1'b0;
      exp_len = L;
      hold_cfg = hold; log_q.delete(); d0 = done_cnt; n_reads = 0;

      @(posedge clk); #2;
      i_start = 1'b1; i_segment = seg; i_offset = off; i_length = len[AW:0];
      @(posedge clk); #2;
      i_start = 1'b0;
      chk("busy_after_start", {31'd0, o_busy}, 32'd1);
      if (poke) begin
         repeat (60) @(posedge clk);
         #2 i_start = 1'b1; i_segment = 8'h01; i_offset = 8'h33; i_length = 9'd5;
         @(posedge clk); #2 i_start = 1'b0;
      end
      if (abort_at > 0) begin
         for (c = 0; c < 20000 && n_reads < abort_at; c++) @(posedge clk);
         chk("abort_reached", n_reads, abort_at);
         #2 i_reset = 1'b1;
         #1;
         chk("abort_busy",   {31'd0, o_busy},      32'd0);
         chk("abort_enable", {31'd0, o_enableI2C}, 32'd0);
         chk("abort_done",   {31'd0, o_done},      32'd0);
         repeat (2) @(posedge clk);
         #2 i_reset = 1'b0;
         return;
      end
      for (c = 0; c < 20000 && done_cnt == d0; c++) @(posedge clk);
      chk("done_seen", done_cnt - d0, 32'd1);
      chk("seq_len", log_q.size(), exp_q.size());
      mism = 0;
      for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) if (log_q[i] != exp_q[i]) mism++;
      chk("seq", mism, 32'd0);
      @(posedge clk); #2 rd_chk = 1'b1;
      for (int i = 0; i < L; i++) begin
         i_rdAddr = 8'(i);
         @(posedge clk); #2;
      end
      rd_chk = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      i_reset = 1'b1; i_start = 1'b0; i_segment = 8'h00; i_offset = 8'h00; i_length = '0;
      i_rdAddr = '0; i_completeI2C = 1'b1; i_byteReceivedI2C = 8'h00;
      for (int i = 0; i < 1024; i++) eeprom[i] = 8'(i * 37 + 11);
      for (int k = 0; k < 8; k++) eeprom[k] = hdr[k];
      eeprom[256] = 8'h02;
      fix_block(0); fix_block(128); fix_block(256); fix_block(384);
      #12;
      chk("rst_busy",  {31'd0, o_busy},       32'd0);
      chk("rst_done",  {31'd0, o_done},       32'd0);
      chk("rst_en",    {31'd0, o_enableI2C},  32'd0);
      chk("rst_ck",    {31'd0, o_checksumOk}, 32'd0);
      chk("rst_hdr",   {31'd0, o_headerOk},   32'd0);
      chk("rst_instr", {30'd0, o_instructionI2C}, 32'd0);
      chk("rst_tx",    {24'd0, o_byteToSendI2C},  32'd0);
      chk("rst_bytes", {23'd0, o_bytesRead},  32'd0);
      chk("rst_rd",    {24'd0, o_rdData},     32'd0);
      @(posedge clk); #2 i_reset = 1'b0;

      // valid 128-byte base block
      run(8'h00, 8'h00, 128, 1, 1'b0, 0);
      chk("t1_ck", {31'd0, o_checksumOk}, 32'd1);
      chk("t1_hdr", {31'd0, o_headerOk}, 32'd1);
      chk("t1_bytes", {23'd0, o_bytesRead}, 32'd128);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #2 i_rdAddr = 8'(i);
         @(posedge clk); #2 chk("t1_rd_hdr", {24'd0, o_rdData}, {24'd0, hdr[i]});
      end
      // corrupted last byte of block 0
      eeprom[127] = eeprom[127] + 8'd1;
      run(8'h00, 8'h00, 128, 1, 1'b0, 0);
      chk("t2_ck", {31'd0, o_checksumOk}, 32'd0);
      chk("t2_hdr", {31'd0, o_headerOk}, 32'd1);
      eeprom[127] = eeprom[127] - 8'd1;
      // segment 1 (extension block)
      run(8'h01, 8'h00, 128, 1, 1'b0, 0);
      chk("t3_hdr", {31'd0, o_headerOk}, 32'd0);
      chk("t3_ck", {31'd0, o_checksumOk}, 32'd1);
      // two blocks, second bad then good
      eeprom[200] = eeprom[200] ^ 8'h01;
      run(8'h00, 8'h00, 256, 1, 1'b0, 0);
      chk("t4_ck_bad", {31'd0, o_checksumOk}, 32'd0);
      eeprom[200] = eeprom[200] ^ 8'h01;
      run(8'h00, 8'h00, 256, 1, 1'b0, 0);
      chk("t4_ck_good", {31'd0, o_checksumOk}, 32'd1);
      chk("t4_bytes", {23'd0, o_bytesRead}, 32'd256);
      // reset mid-read, then a clean transfer
      run(8'h00, 8'h00, 128, 1, 1'b0, 40);
      run(8'h00, 8'h00, 128, 1, 1'b0, 0);
      // long stale completeI2C plus start pulse while busy
      run(8'h00, 8'h00, 128, 3, 1'b1, 0);
      // device offset wrap, partial block unchecked
      run(8'h00, 8'd200, 100, 1, 1'b0, 0);
      chk("t7_hdr", {31'd0, o_headerOk}, 32'd0);
      chk("t7_ck", {31'd0, o_checksumOk}, 32'd1);
      // length clamps and short read
      run(8'h00, 8'h00, 0, 1, 1'b0, 0);
      chk("t8_bytes", {23'd0, o_bytesRead}, 32'd256);
      run(8'h00, 8'h00, 300, 1, 1'b0, 0);
      run(8'h00, 8'h00, 5, 1, 1'b0, 0);
      chk("t9_hdr", {31'd0, o_headerOk}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
